// File: rtl/cv32e40p_perm_fault_detector_ft_if.sv
// Permanent-fault detector bus: voter results in, sticky masks out.
// Master drives the vote results; slave is the detector.
interface cv32e40p_perm_fault_detector_ft_if;
    logic       alu_valid_i;
    logic       mult_valid_i;
    logic [3:0] alu_active_i;
    logic [2:0] mult_active_i;
    logic [3:0] alu_err_i;
    logic [2:0] mult_err_i;
    logic       clear_i;
    logic [3:0] permanent_faulty_alu_o;
    logic [2:0] permanent_faulty_mult_o;
    logic       new_fault_o;
    logic       vote_ambiguous_o;

    modport master (
        output alu_valid_i,
        output mult_valid_i,
        output alu_active_i,
        output mult_active_i,
        output alu_err_i,
        output mult_err_i,
        output clear_i,
        input  permanent_faulty_alu_o,
        input  permanent_faulty_mult_o,
        input  new_fault_o,
        input  vote_ambiguous_o
    );

    modport slave (
        input  alu_valid_i,
        input  mult_valid_i,
        input  alu_active_i,
        input  mult_active_i,
        input  alu_err_i,
        input  mult_err_i,
        input  clear_i,
        output permanent_faulty_alu_o,
        output permanent_faulty_mult_o,
        output new_fault_o,
        output vote_ambiguous_o
    );
endinterface

// File: rtl/cv32e40p_perm_fault_detector_ft.sv
// Permanent-fault classifier for the replicated ALU/MULT EX stage.
// Seven windowed error trackers (ALU0-3 at bits 0-3, MULT0-2 at bits 4-6).
module cv32e40p_perm_fault_detector_ft #(
    parameter int unsigned ERR_THRESHOLD = 8,
    parameter int unsigned WINDOW        = 64
) (
    input logic clk,
    input logic rst_n,
    cv32e40p_perm_fault_detector_ft_if.slave bus
);
    localparam int unsigned N_TRK = 7;
    localparam int unsigned EW = $clog2(ERR_THRESHOLD + 1);
    localparam int unsigned WW = $clog2(WINDOW);

    localparam logic [EW-1:0] ERR_LAST = EW'(ERR_THRESHOLD - 1);
    localparam logic [EW-1:0] ERR_INC  = EW'(1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW - 1);
    localparam logic [WW-1:0] WIN_INC  = WW'(1);

    logic [EW-1:0]    err_cnt_q [N_TRK];
    logic [EW-1:0]    err_cnt_d [N_TRK];
    logic [WW-1:0]    win_cnt_q [N_TRK];
    logic [WW-1:0]    win_cnt_d [N_TRK];
    logic [N_TRK-1:0] perm_q;
    logic [N_TRK-1:0] perm_d;
    logic             new_fault_q;
    logic             new_fault_d;
    logic             amb_q;
    logic             amb_d;

    logic [3:0]       alu_flag;
    logic [2:0]       mult_flag;
    logic             alu_amb;
    logic             mult_amb;
    logic [N_TRK-1:0] trk_op;
    logic [N_TRK-1:0] trk_err;

    // Classify this cycle's vote: which trackers see an op, and which
    // of those count an error (ambiguous votes blame nobody).
    always_comb begin
        alu_flag  = bus.alu_err_i & bus.alu_active_i & ~perm_q[3:0];
        mult_flag = bus.mult_err_i & bus.mult_active_i & ~perm_q[6:4];
        alu_amb   = bus.alu_valid_i && ($countones(alu_flag) >= 2);
        mult_amb  = bus.mult_valid_i && ($countones(mult_flag) >= 2);
        trk_op    = {{3{bus.mult_valid_i}}, {4{bus.alu_valid_i}}}
                  & {bus.mult_active_i, bus.alu_active_i}
                  & ~perm_q;
        trk_err   = trk_op
                  & {bus.mult_err_i, bus.alu_err_i}
                  & ~{{3{mult_amb}}, {4{alu_amb}}};
    end

    // Per-tracker window/error update; clear wipes everything.
    always_comb begin
        err_cnt_d = err_cnt_q;
        win_cnt_d = win_cnt_q;
        perm_d    = perm_q;
        for (int u = 0; u < N_TRK; u++) begin
            if (trk_op[u]) begin
                if (trk_err[u] && (err_cnt_q[u] == ERR_LAST)) begin
                    perm_d[u] = 1'b1;
                end else if (win_cnt_q[u] == WIN_LAST) begin
                    win_cnt_d[u] = '0;
                    err_cnt_d[u] = '0;
                end else begin
                    win_cnt_d[u] = win_cnt_q[u] + WIN_INC;
                    if (trk_err[u]) begin
                        err_cnt_d[u] = err_cnt_q[u] + ERR_INC;
                    end
                end
            end
        end
        if (bus.clear_i) begin
            err_cnt_d = '{default: '0};
            win_cnt_d = '{default: '0};
            perm_d    = '0;
        end
    end

    // Pulse outputs: one cycle after a mask bit rises or a vote is split.
    always_comb begin
        new_fault_d = |(perm_d & ~perm_q);
        amb_d       = (alu_amb || mult_amb) && !bus.clear_i;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int u = 0; u < N_TRK; u++) begin
                err_cnt_q[u] <= '0;
                win_cnt_q[u] <= '0;
            end
            perm_q      <= '0;
            new_fault_q <= 1'b0;
            amb_q       <= 1'b0;
        end else begin
            for (int u = 0; u < N_TRK; u++) begin
                err_cnt_q[u] <= err_cnt_d[u];
                win_cnt_q[u] <= win_cnt_d[u];
            end
            perm_q      <= perm_d;
            new_fault_q <= new_fault_d;
            amb_q       <= amb_d;
        end
    end

    assign bus.permanent_faulty_alu_o  = perm_q[3:0];
    assign bus.permanent_faulty_mult_o = perm_q[6:4];
    assign bus.new_fault_o             = new_fault_q;
    assign bus.vote_ambiguous_o        = amb_q;
endmodule

// File: tb/tb_cv32e40p_perm_fault_detector_ft.sv
// Bench for the permanent-fault detector: directed vote sequences,
// a per-replica window model, and literal checkpoints.
module tb_cv32e40p_perm_fault_detector_ft;
    localparam int THR = 8;
    localparam int WIN = 64;

    logic clk;
    logic rst_n;

    cv32e40p_perm_fault_detector_ft_if bif ();

    cv32e40p_perm_fault_detector_ft #(
        .ERR_THRESHOLD(THR),
        .WINDOW       (WIN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_miss;
    int nf_cnt;
    int amb_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: per replica, ops seen and errors counted in the current
    // window; a replica is condemned once it reaches THR errors.
    int  m_err [7];
    int  m_ops [7];
    bit  m_perm[7];
    bit  e_nf;
    bit  e_amb;
    bit  model_ok;

    always @(posedge clk) begin : model
        logic [6:0] v;
        logic [6:0] a;
        logic [6:0] e;
        bit         amb_g[2];
        bit         rose;
        int         cnt;
        int         errs;
        int         ops;
        model_ok = 1'b1;
        if (!rst_n || bif.clear_i) begin
            for (int u = 0; u < 7; u++) begin
                m_err[u]  = 0;
                m_ops[u]  = 0;
                m_perm[u] = 1'b0;
            end
            e_nf  = 1'b0;
            e_amb = 1'b0;
        end else begin
            v = {{3{bif.mult_valid_i}}, {4{bif.alu_valid_i}}};
            a = {bif.mult_active_i, bif.alu_active_i};
            e = {bif.mult_err_i, bif.alu_err_i};
            for (int g = 0; g < 2; g++) begin
                cnt = 0;
                for (int u = (g == 0 ? 0 : 4); u <= (g == 0 ? 3 : 6); u++)
                    if (v[u] && a[u] && !m_perm[u] && e[u]) cnt++;
                amb_g[g] = (cnt >= 2);
            end
            rose = 1'b0;
            for (int u = 0; u < 7; u++) begin
                if (v[u] && a[u] && !m_perm[u]) begin
                    errs = m_err[u];
                    if (e[u] && !amb_g[u >= 4 ? 1 : 0]) errs++;
                    ops = m_ops[u] + 1;
                    if (errs >= THR) begin
                        m_perm[u] = 1'b1;
                        rose = 1'b1;
                    end else if (ops == WIN) begin
                        m_err[u] = 0;
                        m_ops[u] = 0;
                    end else begin
                        m_err[u] = errs;
                        m_ops[u] = ops;
                    end
                end
            end
            e_nf  = rose;
            e_amb = amb_g[0] || amb_g[1];
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin : compare
        logic [3:0] ea;
        logic [2:0] em;
        if (model_ok) begin
            for (int u = 0; u < 4; u++) ea[u] = m_perm[u];
            for (int u = 0; u < 3; u++) em[u] = m_perm[u + 4];
            chk("alu_mask", 32'(bif.permanent_faulty_alu_o), 32'(ea));
            chk("mult_mask", 32'(bif.permanent_faulty_mult_o), 32'(em));
            chk("new_fault", 32'(bif.new_fault_o), 32'(e_nf));
            chk("ambiguous", 32'(bif.vote_ambiguous_o), 32'(e_amb));
            if (bif.new_fault_o === 1'b1) nf_cnt++;
            if (bif.vote_ambiguous_o === 1'b1) amb_cnt++;
        end
    end

    task automatic drive(input bit av, input logic [3:0] aa,
                         input logic [3:0] ae, input bit mv,
                         input logic [2:0] ma, input logic [2:0] me,
                         input bit clr);
        bif.alu_valid_i   = av;
        bif.alu_active_i  = aa;
        bif.alu_err_i     = ae;
        bif.mult_valid_i  = mv;
        bif.mult_active_i = ma;
        bif.mult_err_i    = me;
        bif.clear_i       = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic alu_op(input logic [3:0] aa, input logic [3:0] ae);
        drive(1'b1, aa, ae, 1'b0, 3'b000, 3'b000, 1'b0);
    endtask

    task automatic mult_op(input logic [2:0] ma, input logic [2:0] me);
        drive(1'b0, 4'b0000, 4'b0000, 1'b1, ma, me, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 3'b000, 3'b000, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        idle();
        rst_n = 1'b1;
    endtask

    task automatic pin(input string nm, input logic [3:0] alu,
                       input logic [2:0] mult);
        chk({nm, "_alu"}, 32'(bif.permanent_faulty_alu_o), 32'(alu));
        chk({nm, "_mult"}, 32'(bif.permanent_faulty_mult_o), 32'(mult));
    endtask

    initial begin
        n_vec = 0; n_miss = 0; nf_cnt = 0; amb_cnt = 0;
        model_ok = 1'b0;
        rst_n = 1'b0;
        bif.alu_valid_i = 1'b0; bif.alu_active_i = '0; bif.alu_err_i = '0;
        bif.mult_valid_i = 1'b0; bif.mult_active_i = '0;
        bif.mult_err_i = '0; bif.clear_i = 1'b0;

        do_reset();
        pin("reset", 4'b0000, 3'b000);
        chk("reset_nf", 32'(bif.new_fault_o), 32'd0);
        chk("reset_amb", 32'(bif.vote_ambiguous_o), 32'd0);

        // ALU1 persistent fault
        nf_cnt = 0;
        for (int i = 0; i < 7; i++) alu_op(4'b0111, 4'b0010);
        pin("alu1_seven", 4'b0000, 3'b000);
        alu_op(4'b0111, 4'b0010);
        pin("alu1_perm", 4'b0010, 3'b000);
        chk("alu1_nf_high", 32'(bif.new_fault_o), 32'd1);
        idle();
        chk("alu1_nf_low", 32'(bif.new_fault_o), 32'd0);
        idle();
        chk("alu1_nf_pulses", 32'(nf_cnt), 32'd1);

        // Clear together with an erroring op
        drive(1'b1, 4'b0111, 4'b0001, 1'b0, 3'b000, 3'b000, 1'b1);
        pin("clear", 4'b0000, 3'b000);
        chk("clear_nf", 32'(bif.new_fault_o), 32'd0);
        for (int i = 0; i < 7; i++) alu_op(4'b0111, 4'b0001);
        pin("clear_seven", 4'b0000, 3'b000);
        alu_op(4'b0111, 4'b0001);
        pin("clear_eighth", 4'b0001, 3'b000);

        // Reset together with an erroring op
        do_reset();
        for (int i = 0; i < 8; i++) alu_op(4'b0111, 4'b0010);
        pin("pre_rst", 4'b0010, 3'b000);
        rst_n = 1'b0;
        alu_op(4'b0111, 4'b0001);
        rst_n = 1'b1;
        pin("rst_mid", 4'b0000, 3'b000);
        chk("rst_mid_nf", 32'(bif.new_fault_o), 32'd0);
        for (int i = 0; i < 7; i++) alu_op(4'b0111, 4'b0001);
        pin("rst_seven", 4'b0000, 3'b000);
        alu_op(4'b0111, 4'b0001);
        pin("rst_eighth", 4'b0001, 3'b000);

        // Transient forgiveness across a window wrap
        do_reset();
        for (int i = 0; i < 7; i++) alu_op(4'b0001, 4'b0001);
        for (int i = 0; i < 57; i++) alu_op(4'b0001, 4'b0000);
        for (int i = 0; i < 7; i++) alu_op(4'b0001, 4'b0001);
        pin("transient", 4'b0000, 3'b000);
        alu_op(4'b0001, 4'b0001);
        pin("transient_8th", 4'b0001, 3'b000);

        // Error on the wrapping op itself is discarded
        do_reset();
        for (int i = 0; i < 6; i++) alu_op(4'b0001, 4'b0001);
        for (int i = 0; i < 57; i++) alu_op(4'b0001, 4'b0000);
        alu_op(4'b0001, 4'b0001);
        for (int i = 0; i < 7; i++) alu_op(4'b0001, 4'b0001);
        pin("wrap_err", 4'b0000, 3'b000);
        alu_op(4'b0001, 4'b0001);
        pin("wrap_err_8th", 4'b0001, 3'b000);

        // A perm replica no longer makes a vote ambiguous
        idle();
        amb_cnt = 0;
        for (int i = 0; i < 8; i++) alu_op(4'b0111, 4'b0011);
        pin("perm_not_amb", 4'b0011, 3'b000);
        idle();
        chk("perm_not_amb_cnt", 32'(amb_cnt), 32'd0);

        // Ambiguous votes
        do_reset();
        amb_cnt = 0;
        for (int i = 0; i < 10; i++) alu_op(4'b0111, 4'b0011);
        pin("ambig", 4'b0000, 3'b000);
        chk("ambig_pulse", 32'(bif.vote_ambiguous_o), 32'd1);
        idle();
        chk("ambig_cnt", 32'(amb_cnt), 32'd10);

        // MULT path with inactive ALU3 errors interleaved
        do_reset();
        for (int i = 0; i < 8; i++) begin
            mult_op(3'b111, 3'b100);
            alu_op(4'b0111, 4'b1000);
        end
        pin("mult", 4'b0000, 3'b100);

        // Two rises on consecutive ops give two pulses
        do_reset();
        nf_cnt = 0;
        for (int i = 0; i < 7; i++) begin
            alu_op(4'b0111, 4'b0001);
            alu_op(4'b0111, 4'b0100);
        end
        pin("dual_seven", 4'b0000, 3'b000);
        alu_op(4'b0111, 4'b0001);
        alu_op(4'b0111, 4'b0100);
        pin("dual", 4'b0101, 3'b000);
        idle();
        idle();
        chk("dual_nf_cnt", 32'(nf_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/cv32e40p_perm_fault_detector_ft.md
# cv32e40p_perm_fault_detector_ft

Classifies functional-unit faults as permanent for the fault-tolerant EX stage. Per-replica error counters, sampled on each executed ALU/MULT operation, accumulate voter mismatches inside a sliding operation window. A replica whose count reaches a threshold is latched as permanently faulty. The resulting sticky masks drive the permanent-fault inputs of the ALU/MULT dispatcher, which uses them to reselect replicas.

## Interface
Parameters:
- ERR_THRESHOLD, default 8: errors within one window that mark a replica permanent; must be ≥1.
- WINDOW, default 64: executed ops per replica per window; must be ≥2.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: **synchronous, active-low reset.**
- alu_valid_i, input, 1: one ALU op completed voting this cycle.
- mult_valid_i, input, 1: one MULT op completed voting this cycle; never high together with alu_valid_i.
- alu_active_i, input, 4: ALU replicas that executed this op.
- mult_active_i, input, 3: MULT replicas that executed this op.
- alu_err_i, input, 4: per-ALU mismatch against the voted result; qualified by alu_valid_i.
- mult_err_i, input, 3: per-MULT mismatch; qualified by mult_valid_i.
- clear_i, input, 1: software clear of all state.
- permanent_faulty_alu_o, output, 4: sticky permanent-fault mask, ALUs.
- permanent_faulty_mult_o, output, 3: sticky permanent-fault mask, MULTs.
- new_fault_o, output, 1: one-cycle pulse when any mask bit rises.
- vote_ambiguous_o, output, 1: one-cycle pulse when an op had ≥2 flagged replicas.

## Operation
- There are 7 independent replica trackers: ALU0–3 and MULT0–2. Each tracker has:
  - err_cnt, width $clog2(ERR_THRESHOLD+1), saturating.
  - win_cnt, width $clog2(WINDOW).
  - perm, 1 bit.
- op event for tracker u: the group valid is high, the replica's active bit is set, and perm[u]=0.
- err event: an op event with the replica's err bit set, and the op is not ambiguous.
- Ambiguous op: 2 or more err bits set among active, non-perm replicas of the group.
  - No tracker counts an error on that op; window counters still advance.
  - vote_ambiguous_o pulses on the next cycle.
- On an op event, in priority order:
  1. err event and err_cnt+1 == ERR_THRESHOLD: perm <= 1. err_cnt and win_cnt are frozen from then on.
  2. win_cnt == WINDOW-1 (window wrap): win_cnt <= 0 and err_cnt <= 0. The wrapping op's error is discarded unless it triggered rule 1.
  3. Otherwise: win_cnt+1, plus err_cnt+1 on an err event.
- Err bits on inactive or already-perm replicas are ignored.
- new_fault_o is registered. It is high in the first cycle any perm bit reads 1, and it is a single pulse even if several bits rise at once.
- clear_i: all counters, perm bits and pulses go to 0 at the next edge. Inputs presented that cycle are discarded.
- Priority: rst_n low > clear_i > update.
- All 4 ALUs becoming perm is legal. The block takes no special action; the dispatcher reports total failure.

## Timing
- Reset values: permanent_faulty_alu_o=4'b0000, permanent_faulty_mult_o=3'b000, new_fault_o=0, vote_ambiguous_o=0, all counters 0.
- Latency: an error on edge N's sampled inputs sets its perm bit at edge N, so the bit is visible in cycle N+1. new_fault_o is high during that same cycle N+1 only.
- All outputs come directly from flops; there is no combinational input-to-output path.
- One op per cycle per group. Back-to-back valids are counted every cycle.
- Reset or clear asserted mid-window loses all partial counts. The first op after release starts window 0.
- Saturation: err_cnt never exceeds ERR_THRESHOLD-1 while perm=0.

## Test plan
- ALU1 persistent fault: 8 consecutive alu_valid_i with alu_active_i=0111 and alu_err_i=0010.
  - Expect permanent_faulty_alu_o=0010 the cycle after the 8th op.
  - Expect new_fault_o high for exactly that one cycle.
- Transient forgiveness: ALU0 errs on ops 0–6, then 57 clean ops (window wraps at op 63), then 7 more errors.
  - Expect the mask to stay 0000.
  - An 8th error in the new window sets bit 0.
- Ambiguity: 10 ops with alu_err_i=0011 and active 0111.
  - Expect the mask to stay 0000.
  - Expect vote_ambiguous_o to pulse once per op.
- MULT path: mult_err_i=100 on 8 ops, with alu_valid_i interleaved carrying ALU errors on ALU3 (inactive).
  - Expect permanent_faulty_mult_o=100 and ALU mask 0000.
- Clear and reset mid-operation:
  - With the ALU mask at 0010, pulse clear_i together with an alu_valid_i carrying an error. Expect all outputs 0 next cycle and that op ignored.
  - Repeat with rst_n low. Expect identical results.
- Simultaneous rise: ALU2 and MULT0 cannot rise in the same cycle. Instead, drive ALU0 and ALU2 to 7 errors each via alternating single-error ops, then give ALU0 and ALU2 their 8th errors on consecutive ops.
  - Expect two separate new_fault_o pulses.
  - Expect the final ALU mask 0101.
